// File: rtl/bpsk_pkg.sv
// Shared definitions for the BPSK transmit scheduler: FSM encoding and send-pulse length.
package bpsk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ARB        = 3'd1,
        ST_SEND       = 3'd2,
        ST_WAIT_START = 3'd3,
        ST_WAIT_END   = 3'd4,
        ST_GAP        = 3'd5
    } sched_state_t;

    // tx_send is held long enough to pass the modulator's 2-flop edge detector
    localparam int SEND_HOLD = 4;

endpackage

// File: rtl/bpsk_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    int cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                idx         = IDX_W'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bpsk_tx_scheduler.sv
// Round-robin scheduler granting one requester at a time to a BPSK modulator, with inter-frame gap.
// Optional watchdog on the modulator handshake is enabled by defining BPSK_SCHED_TIMEOUT_EN.
module bpsk_tx_scheduler
    import bpsk_pkg::*;
#(
    parameter int          NUM_REQ        = 2,
    parameter int          ADDR_WIDTH     = 8,
    parameter int          LEN_WIDTH      = 8,
    parameter int          GAP_CYCLES     = 1024,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd2000000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_base,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            done,
    output logic [NUM_REQ-1:0]            err,
    output logic                          tx_send,
    output logic [ADDR_WIDTH-1:0]         tx_base,
    output logic [LEN_WIDTH-1:0]          tx_len,
    input  logic                          tx_busy,
    output logic                          sched_busy,
    output logic [2:0]                    state_dbg
);

    // Handshake: a requester raises req[i] with stable req_base/req_len slices and holds them
    // until done[i]; err[i] accompanies done[i] when the frame was not transmitted.
    localparam int IDX_W = $clog2(NUM_REQ);

    sched_state_t          state, state_n;
    logic [15:0]           cnt;
    logic [IDX_W-1:0]      rr_ptr, ptr_next, arb_idx;
    logic [NUM_REQ-1:0]    arb_grant;
    logic                  arb_valid;
    logic [ADDR_WIDTH-1:0] sel_base;
    logic [LEN_WIDTH-1:0]  sel_len;
    logic                  send_last, gap_last, timeout;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    assign sel_base  = req_base[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_len   = req_len[int'(arb_idx)*LEN_WIDTH +: LEN_WIDTH];
    assign ptr_next  = (int'(arb_idx) == NUM_REQ-1) ? '0 : arb_idx + IDX_W'(1);
    assign send_last = (cnt == 16'(SEND_HOLD-1));
    assign gap_last  = (cnt == 16'(GAP_CYCLES-1));
    assign state_dbg = state;

`ifdef BPSK_SCHED_TIMEOUT_EN
    logic [31:0] wd_cnt;

    // Counts from WAIT_START entry through WAIT_END without restarting
    always_ff @(posedge clk) begin
        if (rst || !(state == ST_WAIT_START || state == ST_WAIT_END)) wd_cnt <= '0;
        else                                                           wd_cnt <= wd_cnt + 32'd1;
    end

    assign timeout = (state == ST_WAIT_START || state == ST_WAIT_END) &&
                     (wd_cnt == TIMEOUT_CYCLES - 32'd1);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:       if (|req) state_n = ST_ARB;
            ST_ARB: begin
                if (!arb_valid)          state_n = ST_IDLE;
                else if (sel_len == '0)  state_n = ST_GAP;
                else                     state_n = ST_SEND;
            end
            ST_SEND:       if (send_last) state_n = ST_WAIT_START;
            ST_WAIT_START: begin
                if (tx_busy)      state_n = ST_WAIT_END;
                else if (timeout) state_n = ST_GAP;
            end
            ST_WAIT_END:   if (!tx_busy || timeout) state_n = ST_GAP;
            ST_GAP:        if (gap_last) state_n = (|req) ? ST_ARB : ST_IDLE;
            default:       state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            sched_busy <= 1'b0;
        end else begin
            state      <= state_n;
            sched_busy <= (state_n != ST_IDLE);
            cnt        <= (state_n != state) ? 16'd0 : cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant   <= '0;
            done    <= '0;
            err     <= '0;
            tx_send <= 1'b0;
            tx_base <= '0;
            tx_len  <= '0;
            rr_ptr  <= '0;
        end else begin
            done <= '0;
            err  <= '0;
            case (state)
                ST_ARB: begin
                    if (arb_valid) begin
                        tx_base <= sel_base;
                        tx_len  <= sel_len;
                        rr_ptr  <= ptr_next;
                        // A zero-length frame completes immediately with an error
                        if (sel_len == '0) begin
                            done <= arb_grant;
                            err  <= arb_grant;
                        end else begin
                            grant   <= arb_grant;
                            tx_send <= 1'b1;
                        end
                    end
                end
                ST_SEND: if (send_last) tx_send <= 1'b0;
                ST_WAIT_START: begin
                    if (!tx_busy && timeout) begin
                        done  <= grant;
                        err   <= grant;
                        grant <= '0;
                    end
                end
                ST_WAIT_END: begin
                    if (!tx_busy) begin
                        done  <= grant;
                        grant <= '0;
                    end else if (timeout) begin
                        done  <= grant;
                        err   <= grant;
                        grant <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bpsk_tx_scheduler.sv
// Self-checking bench for bpsk_tx_scheduler: directed scenarios plus randomized frames vs a frame-level model.
`timescale 1ns/1ps
module tb_bpsk_tx_scheduler;

    localparam int          N    = 2;
    localparam int          AW   = 8;
    localparam int          LW   = 8;
    localparam int          GAP  = 1024;
    localparam int          HOLD = 4;
    localparam logic [31:0] TMO  = 32'd100;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_base;
    logic [N*LW-1:0] req_len;
    logic [N-1:0]    grant, done, err;
    logic            tx_send;
    logic [AW-1:0]   tx_base;
    logic [LW-1:0]   tx_len;
    logic            tx_busy;
    logic            sched_busy;
    logic [2:0]      state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int m_ptr = 0;
    int busy_len = 10;
    bit mod_en = 1'b1;
    int busy_fall_cyc = 0;
    int lens[N];
    int bases[N];
    logic [2*N-1:0] exp_q[$];

    bpsk_tx_scheduler #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .LEN_WIDTH(LW),
        .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_base(req_base), .req_len(req_len),
        .grant(grant), .done(done), .err(err), .tx_send(tx_send),
        .tx_base(tx_base), .tx_len(tx_len), .tx_busy(tx_busy),
        .sched_busy(sched_busy), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "bench time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // modulator: busy starts a few cycles after the send rise and lasts busy_len cycles
    initial begin
        logic send_prev;
        send_prev = 1'b0;
        tx_busy   = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_send === 1'b1 && !send_prev && mod_en) begin
                repeat (6) @(negedge clk);
                tx_busy = 1'b1;
                repeat (busy_len) @(negedge clk);
                tx_busy = 1'b0;
                busy_fall_cyc = cyc;
            end
            send_prev = tx_send;
        end
    end

    // every send pulse must be exactly HOLD cycles wide
    initial begin
        int run;
        run = 0;
        forever begin
            @(negedge clk);
            if (tx_send === 1'b1) run++;
            else begin
                if (run != 0) check("send_width", run, HOLD);
                run = 0;
            end
        end
    end

    // driver tasks
    task automatic apply_data();
        for (int i = 0; i < N; i++) begin
            req_len[i*LW +: LW]  = LW'(lens[i]);
            req_base[i*AW +: AW] = AW'(bases[i]);
        end
    endtask

    task automatic randomize_slot(input int i);
        lens[i]  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
        bases[i] = int'($urandom_range(0, 255));
    endtask

    function automatic int model_pick(input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    // One frame from arbitration to done; called at a negedge with req/data already driven.
    task automatic run_frame(input int exp_delay, input bit keep, input bit drop_mid);
        int w, waited;
        logic [N-1:0]   oh;
        logic [2*N-1:0] exp_de;
        w = model_pick(req);
        if (w < 0) begin
            check("no_request", 0, 1);
            return;
        end
        oh = '0;
        oh[w] = 1'b1;
        exp_de = (lens[w] == 0) ? {oh, oh} : {{N{1'b0}}, oh};
        exp_q.push_back(exp_de);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (grant == '0 && done == '0 && waited < exp_delay + 20);
        check("start_delay", waited, exp_delay);
        if (lens[w] != 0) begin
            check("grant", grant, oh);
            check("tx_base", tx_base, bases[w]);
            check("tx_len", tx_len, lens[w]);
            if (drop_mid) req[w] = 1'b0;
            waited = 0;
            while (done == '0 && waited < 4000) begin
                @(negedge clk);
                waited++;
            end
            if (done == '0) check("done_timeout", 0, 1);
            else            check("done_after_busy", cyc - busy_fall_cyc, 1);
            check("hold_len", tx_len, lens[w]);
            check("grant_cleared", grant, 0);
        end else begin
            check("zero_no_grant", grant, 0);
            check("zero_no_send", tx_send, 0);
        end
        check("done_err", {err, done}, exp_q.pop_front());
        m_ptr = (w + 1) % N;
        if (!keep) req[w] = 1'b0;
    endtask

    task automatic wait_idle(input int exp);
        int waited;
        waited = 0;
        while (sched_busy === 1'b1 && waited < exp + 50) begin
            @(negedge clk);
            waited++;
        end
        check("gap_to_idle", waited, exp);
    endtask

    initial begin
        bit any;
        int waited;
        rst = 1'b1;
        req = '0;
        req_base = '0;
        req_len = '0;
        for (int i = 0; i < N; i++) begin
            lens[i]  = 0;
            bases[i] = 0;
        end
        repeat (5) @(negedge clk);
        check("rst_grant", grant, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_tx_send", tx_send, 0);
        check("rst_tx_base", tx_base, 0);
        check("rst_tx_len", tx_len, 0);
        check("rst_sched_busy", sched_busy, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // single requester, long modulator busy
        lens[0] = 150;
        bases[0] = int'($urandom_range(0, 255));
        lens[1] = 7;
        bases[1] = 3;
        apply_data();
        busy_len = 1000;
        req = 2'b01;
        run_frame(2, 1'b0, 1'b0);
        wait_idle(GAP);

        // zero-length frame from requester 1
        lens[1] = 0;
        apply_data();
        req = 2'b10;
        run_frame(2, 1'b0, 1'b0);
        wait_idle(GAP);

        // both held: grants alternate
        lens[0] = int'($urandom_range(1, 255));
        lens[1] = int'($urandom_range(1, 255));
        apply_data();
        busy_len = 20;
        req = 2'b11;
        run_frame(2, 1'b1, 1'b0);
        for (int f = 0; f < 3; f++) run_frame(GAP + 1, 1'b1, 1'b0);
        req = '0;
        wait_idle(GAP);

        // randomized frames
        for (int f = 0; f < 10; f++) begin
            bit from_idle;
            from_idle = (req == '0);
            if (from_idle) begin
                for (int i = 0; i < N; i++) randomize_slot(i);
                apply_data();
                req = N'($urandom_range(1, (1 << N) - 1));
            end
            busy_len = int'($urandom_range(1, 60));
            run_frame(from_idle ? 2 : GAP + 1, 1'b0, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < N; i++) begin
                    if (!req[i] && $urandom_range(0, 1) == 1) begin
                        randomize_slot(i);
                        req[i] = 1'b1;
                    end
                end
                apply_data();
            end
            if (req == '0) wait_idle(GAP);
        end
        if (req != '0) begin
            req = '0;
            wait_idle(GAP);
        end

        // modulator never answers
        mod_en = 1'b0;
        lens[0] = 20;
        apply_data();
        req = 2'b01;
        waited = 0;
        while (tx_send !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        while (tx_send === 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
`ifdef BPSK_SCHED_TIMEOUT_EN
        waited = 0;
        while (done == '0 && waited < int'(TMO) + 50) begin
            @(negedge clk);
            waited++;
        end
        check("timeout_delay", waited, TMO);
        check("timeout_done_err", {err, done}, 4'b0101);
        m_ptr = 1;
        req = '0;
        wait_idle(GAP);
`else
        any = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (done != '0 || err != '0) any = 1'b1;
        end
        check("no_watchdog", any, 0);
        check("stuck_grant", grant, 2'b01);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        m_ptr = 0;
        @(negedge clk);
`endif
        mod_en = 1'b1;

        // reset while waiting for the end of a frame
        lens[0] = 200;
        apply_data();
        busy_len = 300;
        req = 2'b01;
        waited = 0;
        while (tx_busy !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("busy_seen", tx_busy, 1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_grant", grant, 0);
        check("midrst_tx_send", tx_send, 0);
        check("midrst_sched_busy", sched_busy, 0);
        check("midrst_done", done, 0);
        rst = 1'b0;
        req = '0;
        m_ptr = 0;
        any = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done != '0 || err != '0) any = 1'b1;
        end
        check("midrst_no_pulse", any, 0);
        waited = 0;
        while (tx_busy === 1'b1 && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        check("midrst_idle", sched_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
